// File: rtl/shift_pkg.sv
// Constants shared by the bidirectional shift register and anything driving it.
package shift_pkg;

  localparam bit DIR_LEFT  = 1'b0;
  localparam bit DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_reg_bidir.sv
// Serial-in / parallel-out register that shifts toward the MSB or the LSB.
// Each enabled edge loads d into the vacated end bit; out comes straight from the flops.
module shift_reg_bidir
  import shift_pkg::*;
#(
  parameter int MSB = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           d,
  input  logic           en,
  input  logic           dir,
  output logic [MSB-1:0] out
);

  logic [MSB-1:0] out_q;
  logic [MSB-1:0] out_d;
  logic [MSB-1:0] shl_s;
  logic [MSB-1:0] shr_s;

  // A one-bit register has no slice to keep, so both directions simply load d.
  generate
    if (MSB == 1) begin : g_single
      assign shl_s = d;
      assign shr_s = d;
    end else begin : g_wide
      assign shl_s = {out_q[MSB-2:0], d};
      assign shr_s = {d, out_q[MSB-1:1]};
    end
  endgenerate

  // Next-state select: hold, shift toward MSB, or shift toward LSB.
  always_comb begin
    out_d = out_q;
    if (en) begin
      if (dir == DIR_RIGHT) begin
        out_d = shr_s;
      end else begin
        out_d = shl_s;
      end
    end else begin
      out_d = out_q;
    end
  end

  // State register; rstn is active-high despite its name.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_shift_reg_bidir.sv
// Directed and randomized checks of shift_reg_bidir against an arithmetic model.
module tb_shift_reg_bidir;

  localparam int W = 16;

  logic         clk;
  logic         rstn;
  logic         d;
  logic         en;
  logic         dir;
  logic [W-1:0] out;

  logic [W-1:0] model;
  int           vectors;
  int           miscompares;

  shift_reg_bidir #(.MSB(W)) dut (
    .clk (clk),
    .rstn(rstn),
    .d   (d),
    .en  (en),
    .dir (dir),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] exp);
    vectors++;
    assert (out === exp)
    else begin
      miscompares++;
      $error("FAIL %s: out=%h expected %h", tag, out, exp);
    end
  endtask

  // Drive one cycle, advance the model by plain arithmetic, compare after the edge.
  task automatic step(input logic e, input logic di, input logic dd, input string tag);
    @(negedge clk);
    en  = e;
    dir = di;
    d   = dd;
    @(posedge clk);
    #1;
    if (e) begin
      if (di) model = (model >> 1) | (W'(dd) << (W - 1));
      else    model = ((model << 1) | W'(dd)) & 16'hFFFF;
    end
    check(tag, model);
  endtask

  task automatic load(input logic [W-1:0] value);
    for (int i = W - 1; i >= 0; i--) step(1'b1, 1'b0, value[i], "load");
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rstn = 1'b1;
    #1;
    model = 16'h0000;
    check("async_reset", 16'h0000);
    @(negedge clk);
    rstn = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model       = 16'h0000;
    en          = 1'b0;
    dir         = 1'b0;
    d           = 1'b0;
    rstn        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 16'h0000);
    @(negedge clk);
    rstn = 1'b0;

    // 1: asynchronous reset clears a loaded pattern between edges
    load(16'h5A5A);
    check("preload_5a5a", 16'h5A5A);
    pulse_reset();

    // 2: shift left with d=1
    step(1'b1, 1'b0, 1'b1, "left1"); check("left1_const", 16'h0001);
    step(1'b1, 1'b0, 1'b1, "left2"); check("left2_const", 16'h0003);
    step(1'b1, 1'b0, 1'b1, "left3"); check("left3_const", 16'h0007);

    // 3: shift right from zero
    pulse_reset();
    step(1'b1, 1'b1, 1'b1, "right1"); check("right1_const", 16'h8000);
    step(1'b1, 1'b1, 1'b1, "right2"); check("right2_const", 16'hC000);
    step(1'b1, 1'b1, 1'b0, "right3"); check("right3_const", 16'h6000);

    // 4: hold with d and dir toggling
    load(16'h1234);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, i[0], ~i[0], "hold");
      check("hold_const", 16'h1234);
    end

    // 5: alternating fill left, then alternating shift right
    pulse_reset();
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, ~i[0], "alt_left");
    check("alt_aaaa", 16'hAAAA);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1, ~i[0], "alt_right");

    // 6: reset mid-stream with en high, then first edge after release
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "pre_mid");
    @(negedge clk);
    en = 1'b1;
    d  = 1'b1;
    #2;
    rstn = 1'b1;
    #1;
    model = 16'h0000;
    check("mid_reset", 16'h0000);
    @(posedge clk);
    #1;
    check("reset_dominates", 16'h0000);
    @(negedge clk);
    rstn = 1'b0;
    step(1'b1, 1'b0, 1'b1, "release_first");
    check("release_const", 16'h0001);

    // Random traffic, including direction changes while enabled
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
